// File: rtl/j1b_mem_arbiter.sv
// j1b_mem_arbiter: J1B RAM port A shared by core (priority) and WB slave; WB ack/err one cycle after acceptance.
// WB is stalled while losing and forced through after MAX_WAIT losses; `RM0_ARB_STATS_EN enables statistics counters.
module j1b_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int MAX_WAIT = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              j1_run,
  input  logic              j1_req,
  input  logic [ADDR_W-1:0] j1_addr,
  input  logic              j1_wr,
  input  logic [31:0]       j1_d,
  output logic              j1_hold,
  output logic [31:0]       j1_q,
  input  logic [19:0]       wbs_adr,
  input  logic [31:0]       wbs_dat_w,
  input  logic [3:0]        wbs_sel,
  input  logic              wbs_we,
  input  logic              wbs_cyc,
  input  logic              wbs_stb,
  output logic              wbs_stall,
  output logic              wbs_ack,
  output logic              wbs_err,
  output logic [31:0]       wbs_dat_r,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_d,
  input  logic [31:0]       ram_q,
  output logic [15:0]       stat_wb_forced,
  output logic [15:0]       stat_j1_hold
);
  typedef enum logic {OWNER_J1 = 1'b0, OWNER_WB = 1'b1} owner_e;

  localparam logic [20:0] DEPTH    = 21'(1) << ADDR_W;
  localparam logic [3:0]  WAIT_MAX = 4'(MAX_WAIT);

  owner_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic              started_q, started_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              wb_req, wb_in_range, wb_ram_req, starved, wb_grant, j1_grant;

  // started_q keeps the core frozen for the first cycle after reset.
  always_comb begin
    wb_req      = wbs_cyc & wbs_stb;
    wb_in_range = {1'b0, wbs_adr} < DEPTH;
    wb_ram_req  = wb_req & wb_in_range;
    starved     = wait_cnt_q >= WAIT_MAX;
    wb_grant    = wb_ram_req & (~started_q | ~j1_run | ~j1_req | starved);
    j1_grant    = started_q & j1_run & j1_req & ~wb_grant;
  end

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_be     = '0;
    ram_d      = '0;
    if (wb_grant) begin
      ram_addr_d = wbs_adr[ADDR_W-1:0];
      ram_be     = wbs_sel & {4{wbs_we}};
      ram_d      = wbs_dat_w;
    end else if (j1_grant) begin
      ram_addr_d = j1_addr;
      ram_be     = {4{j1_wr}};
      ram_d      = j1_d;
    end
    ram_wr    = |ram_be;
    ram_addr  = ram_addr_d;
    wbs_stall = wb_ram_req & ~wb_grant;
    j1_hold   = ~started_q | ~j1_run | (j1_req & ~j1_grant);

    wait_cnt_d = '0;
    if (wbs_stall) wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 4'd1;
    ack_d     = wb_grant;
    err_d     = wb_req & ~wb_in_range;
    started_d = 1'b1;
  end

  // Owner of the read issued last cycle; steers the returning RAM data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OWNER_J1: if (wb_grant)  state_d = OWNER_WB;
      OWNER_WB: if (!wb_grant) state_d = OWNER_J1;
      default:                 state_d = OWNER_J1;
    endcase
  end

  always_comb begin
    wbs_dat_r = (state_q == OWNER_WB) ? ram_q : '0;
    j1_q      = ram_q;
    wbs_ack   = ack_q & wbs_cyc;
    wbs_err   = err_q & wbs_cyc;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OWNER_J1;
      wait_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      started_q  <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      started_q  <= started_d;
      ram_addr_q <= ram_addr_d;
    end
  end

`ifdef RM0_ARB_STATS_EN
  logic [15:0] forced_cnt_q, forced_cnt_d, hold_cnt_q, hold_cnt_d;

  // A WB grant while a running core is requesting can only be a starvation override.
  always_comb begin
    forced_cnt_d = forced_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (wb_grant && started_q && j1_run && j1_req && forced_cnt_q != 16'hFFFF)
      forced_cnt_d = forced_cnt_q + 16'd1;
    if (j1_hold && j1_run && hold_cnt_q != 16'hFFFF)
      hold_cnt_d = hold_cnt_q + 16'd1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      forced_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      forced_cnt_q <= forced_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign stat_wb_forced = forced_cnt_q;
  assign stat_j1_hold   = hold_cnt_q;
`else
  assign stat_wb_forced = 16'h0;
  assign stat_j1_hold   = 16'h0;
`endif

endmodule

// File: tb/tb_j1b_mem_arbiter.sv
// Bench for j1b_mem_arbiter: vector table, directed corner sequences and a randomized run against a reference model.
`timescale 1ns/1ps
module tb_j1b_mem_arbiter;
  localparam int ADDR_W   = 13;
  localparam int MAX_WAIT = 4;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              j1_run, j1_req, j1_wr;
  logic [ADDR_W-1:0] j1_addr;
  logic [31:0]       j1_d;
  logic              j1_hold;
  logic [31:0]       j1_q;
  logic [19:0]       wbs_adr;
  logic [31:0]       wbs_dat_w;
  logic [3:0]        wbs_sel;
  logic              wbs_we, wbs_cyc, wbs_stb;
  logic              wbs_stall, wbs_ack, wbs_err;
  logic [31:0]       wbs_dat_r;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_d;
  logic [31:0]       ram_q;
  logic [15:0]       stat_wb_forced, stat_j1_hold;

  int n_checks = 0;
  int n_fail   = 0;

  j1b_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .j1_run(j1_run), .j1_req(j1_req), .j1_addr(j1_addr), .j1_wr(j1_wr), .j1_d(j1_d),
    .j1_hold(j1_hold), .j1_q(j1_q),
    .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_sel(wbs_sel), .wbs_we(wbs_we),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_stall(wbs_stall), .wbs_ack(wbs_ack),
    .wbs_err(wbs_err), .wbs_dat_r(wbs_dat_r),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_be(ram_be), .ram_d(ram_d), .ram_q(ram_q),
    .stat_wb_forced(stat_wb_forced), .stat_j1_hold(stat_j1_hold)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural 8192x32 RAM port A: byte writes, registered write-first read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
  always @(posedge sys_clk) begin
    logic [31:0] w;
    w = mem[ram_addr];
    for (int b = 0; b < 4; b++) if (ram_be[b]) w[8*b +: 8] = ram_d[8*b +: 8];
    if (ram_wr) mem[ram_addr] <= w;
    ram_q <= w;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge sys_clk);
  endtask

  task automatic wb_drive(input logic we, input logic [19:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_dat_w = dat; wbs_sel = sel;
  endtask

  task automatic wb_stb_off();
    wbs_stb = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic wb_end();
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic idle_all();
    wb_end(); wbs_adr = '0; wbs_dat_w = '0; wbs_sel = '0;
    j1_req = 1'b0; j1_wr = 1'b0; j1_addr = '0; j1_d = '0;
  endtask

  // Single WB write with the core idle; consumes two cycles.
  task automatic preload(input logic [19:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_drive(1'b1, adr, dat, sel);
    tick(); wb_stb_off();
    tick(); wb_end();
  endtask

  typedef struct {
    string       name;
    logic        run, jreq, jwr, wreq, wwe;
    logic [19:0] adr;
    logic        e_stall, e_hold, e_wr;
  } vec_t;
  vec_t vecs [8];

  logic [31:0] ref_mem [16];
  int          stalls, losses;
  logic        granted, p_ack, p_err;
  logic [31:0] p_data;
  logic        run_v, jreq_v, jwr_v, cyc_v, stb_v, we_v;
  logic [3:0]  sel_v;
  logic [19:0] adr_v;
  logic [31:0] dat_v, jd_v;
  logic [ADDR_W-1:0] ja_v;
  logic        wreq, inr, wram, wb_wins, core_go, e_stall, e_hold, e_wr;

  initial begin
    vecs[0] = '{"v_idle_run",      1, 0, 0, 0, 0, 20'd0,     0, 0, 0};
    vecs[1] = '{"v_core_wr",       1, 1, 1, 0, 0, 20'd0,     0, 0, 1};
    vecs[2] = '{"v_wb_only_rd",    1, 0, 0, 1, 0, 20'd101,   0, 0, 0};
    vecs[3] = '{"v_wb_only_wr",    1, 0, 0, 1, 1, 20'd102,   0, 0, 1};
    vecs[4] = '{"v_both_core_win", 1, 1, 0, 1, 1, 20'd103,   1, 0, 0};
    vecs[5] = '{"v_halted_wb",     0, 1, 1, 1, 1, 20'd104,   0, 1, 1};
    vecs[6] = '{"v_halted_core",   0, 1, 1, 0, 0, 20'd0,     0, 1, 0};
    vecs[7] = '{"v_oob_with_core", 1, 1, 1, 1, 1, 20'h3000,  0, 0, 1};

    rst_n = 1'b0; j1_run = 1'b0;
    idle_all();
    #3;
    chk("rst_hold", j1_hold, 1'b1);
    chk("rst_ack", wbs_ack, 1'b0);
    chk("rst_err", wbs_err, 1'b0);
    chk("rst_stall", wbs_stall, 1'b0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_dat_r", wbs_dat_r, 32'h0);
    tick(); rst_n = 1'b1;

    // Core halted: write then read back word 5.
    wb_drive(1'b1, 20'd5, 32'hDEADBEEF, 4'hF);
    settle(); chk("t1_wr_stall", wbs_stall, 1'b0); chk("t1_wr_ram_wr", ram_wr, 1'b1);
    tick(); wb_drive(1'b0, 20'd5, 32'h0, 4'hF);
    settle(); chk("t1_wr_ack", wbs_ack, 1'b1); chk("t1_rd_stall", wbs_stall, 1'b0);
    tick(); wb_stb_off();
    settle(); chk("t1_rd_ack", wbs_ack, 1'b1); chk("t1_rd_data", wbs_dat_r, 32'hDEADBEEF);
    tick(); wb_end();

    // Core hammering the port: WB read of word 7 is forced through after MAX_WAIT losses.
    preload(20'd7, 32'hA5A50007, 4'hF);
    j1_run = 1'b1; j1_req = 1'b1; j1_wr = 1'b0; j1_addr = 13'd200;
    wb_drive(1'b0, 20'd7, 32'h0, 4'hF);
    stalls = 0; granted = 1'b0;
    for (int i = 0; i < 10 && !granted; i++) begin
      settle();
      if (wbs_stall) begin
        stalls++;
        chk("t2_hold_while_stalled", j1_hold, 1'b0);
        tick();
      end else begin
        granted = 1'b1;
        chk("t2_hold_on_forced_grant", j1_hold, 1'b1);
      end
    end
    chk("t2_granted", granted, 1'b1);
    chk("t2_stall_cycles", stalls, MAX_WAIT);
    tick(); wb_stb_off();
    settle();
    chk("t2_ack", wbs_ack, 1'b1);
    chk("t2_data", wbs_dat_r, 32'hA5A50007);
    chk("t2_hold_after", j1_hold, 1'b0);
`ifdef RM0_ARB_STATS_EN
    chk("t2_stat_wb_forced", stat_wb_forced, 32'd1);
    chk("t2_stat_j1_hold", stat_j1_hold, 32'd1);
`else
    chk("t2_stat_wb_forced_tied", stat_wb_forced, 32'd0);
`endif
    tick(); wb_end(); j1_run = 1'b0; j1_req = 1'b0;

    // Byte-select write merge.
    preload(20'd9, 32'h11223344, 4'hF);
    preload(20'd9, 32'h0000AB00, 4'b0010);
    wb_drive(1'b0, 20'd9, 32'h0, 4'hF);
    tick(); wb_stb_off();
    settle(); chk("t3_ack", wbs_ack, 1'b1); chk("t3_merged", wbs_dat_r, 32'h1122AB44);
    tick(); wb_end();

    // Out-of-range read.
    wb_drive(1'b0, 20'h2000, 32'h0, 4'hF);
    settle(); chk("t4_stall", wbs_stall, 1'b0); chk("t4_ram_wr_req", ram_wr, 1'b0);
    tick(); wb_stb_off();
    settle();
    chk("t4_err", wbs_err, 1'b1); chk("t4_ack", wbs_ack, 1'b0); chk("t4_ram_wr_resp", ram_wr, 1'b0);
    tick(); wb_end();

    // cyc dropped while the ack is pending.
    wb_drive(1'b0, 20'd5, 32'h0, 4'hF);
    tick(); wb_end();
    settle(); chk("t5_ack_suppressed", wbs_ack, 1'b0);
    tick();

    // Reset pulse with an ack pending.
    j1_run = 1'b1; j1_req = 1'b0;
    wb_drive(1'b0, 20'd5, 32'h0, 4'hF);
    settle(); chk("t6_hold_before", j1_hold, 1'b0);
    tick(); wb_stb_off();
    settle(); chk("t6_ack_pending", wbs_ack, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("t6_ack_cleared", wbs_ack, 1'b0); chk("t6_hold_set", j1_hold, 1'b1);
    idle_all();
    tick(); rst_n = 1'b1;
    tick();

    // Reset pulse with the wait counter part-way.
    j1_req = 1'b1;
    wb_drive(1'b0, 20'd5, 32'h0, 4'hF);
    tick(); tick();
    settle(); chk("t6_cnt_before", dut.wait_cnt_q, 32'd2);
    #1 rst_n = 1'b0;
    #1 chk("t6_cnt_cleared", dut.wait_cnt_q, 32'd0); chk("t6_hold_rst", j1_hold, 1'b1);
    idle_all();
    tick(); rst_n = 1'b1;
    tick();

    // Single-cycle vector table, wait counter idle before each vector.
    foreach (vecs[k]) begin
      j1_run = vecs[k].run; j1_req = vecs[k].jreq; j1_wr = vecs[k].jwr;
      j1_addr = 13'd100; j1_d = 32'h0BAD_0000 + k;
      if (vecs[k].wreq) wb_drive(vecs[k].wwe, vecs[k].adr, 32'h5A5A_0000 + k, 4'hF);
      settle();
      chk({vecs[k].name, "_stall"}, wbs_stall, vecs[k].e_stall);
      chk({vecs[k].name, "_hold"}, j1_hold, vecs[k].e_hold);
      chk({vecs[k].name, "_ram_wr"}, ram_wr, vecs[k].e_wr);
      tick(); wb_stb_off(); j1_req = 1'b0; j1_wr = 1'b0; j1_run = 1'b1;
      tick(); wb_end();
    end

    // Randomized traffic against a rule-level reference model.
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    losses = 0; p_ack = 1'b0; p_err = 1'b0; p_data = '0;
    for (int n = 0; n < 500; n++) begin
      run_v  = ($urandom_range(0, 7) != 0);
      jreq_v = $urandom_range(0, 1) == 1;
      jwr_v  = $urandom_range(0, 1) == 1;
      ja_v   = 13'(64 + $urandom_range(0, 15));
      jd_v   = $urandom;
      cyc_v  = ($urandom_range(0, 9) != 0);
      stb_v  = cyc_v && ($urandom_range(0, 3) != 0);
      adr_v  = ($urandom_range(0, 9) == 0) ? 20'(32'h2000 + $urandom_range(0, 4095))
                                            : 20'(64 + $urandom_range(0, 15));
      we_v   = $urandom_range(0, 1) == 1;
      sel_v  = 4'($urandom_range(0, 15));
      dat_v  = $urandom;
      j1_run = run_v; j1_req = jreq_v; j1_wr = jwr_v; j1_addr = ja_v; j1_d = jd_v;
      wbs_cyc = cyc_v; wbs_stb = stb_v; wbs_adr = adr_v; wbs_we = we_v;
      wbs_sel = sel_v; wbs_dat_w = dat_v;
      settle();
      chk("r_ack", wbs_ack, p_ack & cyc_v);
      chk("r_err", wbs_err, p_err & cyc_v);
      if (p_ack && cyc_v) chk("r_data", wbs_dat_r, p_data);

      wreq    = cyc_v & stb_v;
      inr     = adr_v < 20'd8192;
      wram    = wreq & inr;
      wb_wins = wram && (!run_v || !jreq_v || losses >= MAX_WAIT);
      core_go = run_v && jreq_v && !wb_wins;
      e_stall = wram && !wb_wins;
      e_hold  = !run_v || (jreq_v && !core_go);
      e_wr    = wb_wins ? (we_v && sel_v != 4'h0) : (core_go && jwr_v);
      chk("r_stall", wbs_stall, e_stall);
      chk("r_hold", j1_hold, e_hold);
      chk("r_ram_wr", ram_wr, e_wr);
      if (wb_wins) chk("r_ram_addr_wb", ram_addr, adr_v[ADDR_W-1:0]);
      else if (core_go) chk("r_ram_addr_j1", ram_addr, ja_v);

      if (wb_wins) begin
        if (we_v)
          for (int b = 0; b < 4; b++)
            if (sel_v[b]) ref_mem[adr_v - 64][8*b +: 8] = dat_v[8*b +: 8];
        p_data = ref_mem[adr_v - 64];
      end else if (core_go && jwr_v) begin
        ref_mem[ja_v - 64] = jd_v;
      end
      p_ack  = wb_wins;
      p_err  = wreq && !inr;
      losses = e_stall ? ((losses < MAX_WAIT) ? losses + 1 : losses) : 0;
      tick();
    end
    idle_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/j1b_mem_arbiter.md
Name: j1b_mem_arbiter

Overview:
- Arbitrates the single read/write port A of the J1B program/data RAM between the running J1B core and the pipelined Wishbone slave.
- Lets the host read and patch J1B memory while the core executes, instead of only while the core is held in reset.
- Sits inside the RM0 realization, between the j1 instance, the WB slave decode and the 8192x32 dual-port RAM.
- The core is given priority. A bounded-wait counter ensures the host is never starved.

Parameters:
- ADDR_W, 13, RAM word-address width; memory depth is 2**ADDR_W words.
- MAX_WAIT, 4, maximum consecutive cycles a pending WB request may lose to the core before it is forced through (1..15).

Ports:
- sys_clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- j1_run, in, 1, core out of reset (ctrl bit 0). When 0, WB owns the port unconditionally.
- j1_req, in, 1, core issues a memory read or write this cycle.
- j1_addr, in, ADDR_W, core word address.
- j1_wr, in, 1, core write strobe.
- j1_d, in, 32, core write data.
- j1_hold, out, 1, core clock-enable low: the core must freeze and re-present the same request next cycle.
- j1_q, out, 32, read data to core (ram_q pass-through).
- wbs_adr, in, 20, WB word address.
- wbs_dat_w, in, 32, WB write data.
- wbs_sel, in, 4, WB byte selects.
- wbs_we, in, 1, WB write enable.
- wbs_cyc, in, 1, WB cycle.
- wbs_stb, in, 1, WB strobe.
- wbs_stall, out, 1, WB stall.
- wbs_ack, out, 1, WB acknowledge.
- wbs_err, out, 1, WB error.
- wbs_dat_r, out, 32, WB read data.
- ram_addr, out, ADDR_W, RAM port A address.
- ram_wr, out, 1, RAM port A write.
- ram_be, out, 4, RAM byte-write enables.
- ram_d, out, 32, RAM write data.
- ram_q, in, 32, RAM read data, 1-cycle registered latency.

Behaviour:

Reset values:
- All outputs 0, except j1_hold.
- j1_hold resets to 1, so the core is frozen until the first arbitrated cycle.
- wait_cnt = 0.
- FSM resets to OWNER_J1.

Request decode:
- wb_req = wbs_cyc & wbs_stb.
- In range: wbs_adr < 2**ADDR_W.
- Out of range: never touches the RAM. Accepted with wbs_stall=0 in the request cycle; wbs_err=1 exactly one cycle later; wbs_ack=0 for that transaction.

Grant, evaluated combinationally each cycle:
- j1_run=0: WB is granted every cycle; wbs_stall=0; j1_hold=1.
- j1_run=1 and only one side requesting: that side is granted.
- j1_run=1 and both requesting: the core wins while wait_cnt < MAX_WAIT. Otherwise WB wins and j1_hold=1 for that cycle.
- When WB loses: wbs_stall=1 and the request is not accepted.

wait_cnt:
- Increments on each cycle WB loses.
- Clears on any WB grant or when wb_req=0.
- Saturates at MAX_WAIT.

FSM:
- OWNER_J1 → OWNER_WB on a WB grant.
- OWNER_WB → OWNER_J1 on the first cycle WB is not granted.
- The FSM only tracks the owner of the cycle-(n-1) read, to steer the returning data.

RAM port outputs:
- Driven by the granted side.
- WB grant: ram_be = wbs_sel & {4{wbs_we}}.
- Core grant: ram_be = {4{j1_wr}}.
- ram_wr = |ram_be.
- No grant: ram_wr = 0 and ram_addr holds its previous value.

WB response:
- A granted in-range request gives wbs_ack=1 one cycle later, with wbs_dat_r = ram_q (write-first data on writes).
- Only one transaction is accepted per cycle. Back-to-back accepted requests produce back-to-back acks.

Core read data:
- j1_q = ram_q.
- Valid only in the cycle after a core grant. The core is frozen otherwise, so no data is lost.

cyc dropped:
- If wbs_cyc drops while an ack or err is pending, that ack/err is suppressed (ack = ack_q & wbs_cyc).
- A RAM write already issued stays committed.

j1_run transitions:
- Take effect on the next grant decision.
- An in-flight ack or err still completes.

Reset asserted mid-operation:
- Immediately clears all pending acks, errors and counters.

Optional Feature:
- Macro: RM0_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_wb_forced [15:0]: count of cycles WB won by starvation override.
  - stat_j1_hold [15:0]: count of cycles with j1_hold=1 while j1_run=1.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, both ports still exist and are tied to 0, with no counter logic.

Test Plan:
1. j1_run=0: WB write 0xDEADBEEF to word 5 (sel=4'hF), then read word 5. Required: wbs_stall=0 throughout; acks 1 cycle after each request; read returns 0xDEADBEEF.
2. j1_run=1 with j1_req held high every cycle: single WB read of word 7. Required: wbs_stall=1 for exactly MAX_WAIT=4 cycles; granted on cycle 5 with j1_hold=1 for that one cycle; ack on cycle 6.
3. WB write with wbs_sel=4'b0010, data 0x0000AB00, over a preloaded 0x11223344. Required: the word reads back 0x1122AB44.
4. WB read of wbs_adr=20'h2000 (out of range, ADDR_W=13). Required: wbs_err=1 one cycle later, wbs_ack=0, ram_wr never asserted.
5. Accepted WB read, then wbs_cyc=0 on the next cycle. Required: no ack is observed. With RM0_ARB_STATS_EN defined, scenario 2 must leave stat_wb_forced=1 and stat_j1_hold=1.
6. rst_n pulsed low while an ack is pending. Required: wbs_ack=0, j1_hold=1 and wait_cnt=0 immediately, without waiting for a clock edge.
